// File: rtl/fht_pkg.sv
// Shared definitions for the FHT frame scheduler: state encoding, default
// geometry constants, bank-index type and the bit-reverse helper.
// No ports; imported by fht_sched and fht_sched_obuf.
package fht_pkg;

    // Default bank address width and the derived transform size.
    localparam int FHT_A_BIT = 8;
    localparam int LOG2_N    = FHT_A_BIT + 2;
    localparam int N_POINT   = 1 << LOG2_N;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_UNLOAD
    } sched_state_e;

    typedef logic [1:0] bank_t;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r = r | (((v >> i) & 32'd1) << (w - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_sched_obuf.sv
// Purpose: 2-entry valid/ready output buffer with occupancy count for the unload path.
// Latency: a push is visible on oOUT_VALID/oOUT_DATA the following cycle.
// Backpressure: holds data while iOUT_READY=0; the caller must keep occupancy plus
//   in-flight reads within 2 (oOCC is exported for that purpose).
// Ports: iCLK/iRESET (sync, active-high); iPUSH_VALID/iPUSH_DATA write side;
//   oOUT_VALID/oOUT_DATA/iOUT_READY read side; oOCC current entry count.
module fht_sched_obuf
    import fht_pkg::*;
#(
    parameter int D_BIT = 16
)
(
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iPUSH_VALID,
    input  logic [D_BIT-1:0] iPUSH_DATA,
    output logic             oOUT_VALID,
    output logic [D_BIT-1:0] oOUT_DATA,
    input  logic             iOUT_READY,
    output logic [1:0]       oOCC
);

    logic [D_BIT-1:0] mem_q [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       occ_q;
    logic             pop;

    assign oOUT_VALID = (occ_q != 2'd0);
    assign oOUT_DATA  = mem_q[rptr_q];
    assign oOCC       = occ_q;
    assign pop        = oOUT_VALID & iOUT_READY;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (iPUSH_VALID) begin
                mem_q[wptr_q] <= iPUSH_DATA;
                wptr_q        <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            occ_q <= occ_q + {1'b0, iPUSH_VALID} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fht_sched.sv
// Purpose: frame scheduler for the FHT engine; loads N = 4*2^A_BIT samples into the
//   4-bank work RAM, starts the FHT controller, waits for completion, then unloads.
// Latency: write in the accept cycle; START the cycle after load beat N-1; first
//   result valid 2 cycles after UNLOAD entry, then one sample per cycle if unstalled.
// Backpressure: oIN_READY only in LOAD; unload read issue stalls so buffered plus
//   in-flight reads never exceed 2 entries.
// Optional build macro FHT_SCHED_BITREV_EN: load index is the load count
//   bit-reversed over A_BIT+2 bits (decimation-in-time input order).
// Ports: iCLK/iRESET; input stream iIN_*/oIN_READY; output stream oOUT_*/iOUT_READY;
//   FHT control oFHT_START/iFHT_RDY/iSOURCE_DATA; RAM mux oHOST_OWN, host port
//   oH_BANK/oH_ADDR/oH_WE/oH_WDATA; result set oRD_SET; bank read data iRAM_Q0..3.
module fht_sched
    import fht_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT,
    parameter int D_BIT = 16
)
(
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iIN_VALID,
    input  logic [D_BIT-1:0] iIN_DATA,
    output logic             oIN_READY,
    output logic             oOUT_VALID,
    output logic [D_BIT-1:0] oOUT_DATA,
    output logic             oOUT_LAST,
    input  logic             iOUT_READY,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    input  logic             iSOURCE_DATA,
    output logic             oHOST_OWN,
    output logic [1:0]       oH_BANK,
    output logic [A_BIT-1:0] oH_ADDR,
    output logic             oH_WE,
    output logic [D_BIT-1:0] oH_WDATA,
    output logic             oRD_SET,
    input  logic [D_BIT-1:0] iRAM_Q0,
    input  logic [D_BIT-1:0] iRAM_Q1,
    input  logic [D_BIT-1:0] iRAM_Q2,
    input  logic [D_BIT-1:0] iRAM_Q3
);

    localparam int            IW       = A_BIT + 2;
    localparam logic [IW-1:0] LAST_IDX = '1;

    sched_state_e     state_q, state_d;
    logic [IW-1:0]    load_cnt_q, load_cnt_d;
    logic [IW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [IW-1:0]    out_cnt_q, out_cnt_d;
    logic             issue_done_q, issue_done_d;
    logic             busy_seen_q, busy_seen_d;
    logic             rd_set_q, rd_set_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             inflight_q;
    bank_t            rd_bank_q;

    logic [IW-1:0]    load_idx;
    logic [IW-1:0]    host_idx;
    logic             issue;
    logic             pop;
    logic [1:0]       occ;
    logic [D_BIT-1:0] q_sel;
    logic             obuf_vld;

    // Point index written by the current load beat.
    always_comb begin
`ifdef FHT_SCHED_BITREV_EN
        load_idx = IW'(bit_rev(32'(load_cnt_q), IW));
`else
        load_idx = load_cnt_q;
`endif
    end

    assign host_idx  = (state_q == ST_UNLOAD) ? rd_cnt_q : load_idx;
    assign oH_BANK   = host_idx[1:0];
    assign oH_ADDR   = host_idx[IW-1:2];
    assign oH_WDATA  = iIN_DATA;
    assign oRD_SET   = rd_set_q;
    assign pop       = obuf_vld & iOUT_READY;
    assign oOUT_VALID = obuf_vld;
    assign oOUT_LAST = obuf_vld & (out_cnt_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        out_cnt_d    = out_cnt_q;
        issue_done_d = issue_done_q;
        busy_seen_d  = busy_seen_q;
        rd_set_d     = rd_set_q;
        frame_cnt_d  = frame_cnt_q;
        oIN_READY    = 1'b0;
        oHOST_OWN    = 1'b1;
        oH_WE        = 1'b0;
        oFHT_START   = 1'b0;
        issue        = 1'b0;

        case (state_q)
            ST_LOAD: begin
                oIN_READY = 1'b1;
                if (iIN_VALID) begin
                    oH_WE = 1'b1;
                    if (load_cnt_q == LAST_IDX) begin
                        load_cnt_d = '0;
                        state_d    = ST_START;
                    end else begin
                        load_cnt_d = load_cnt_q + IW'(1);
                    end
                end
            end
            ST_START: begin
                oHOST_OWN   = 1'b0;
                oFHT_START  = 1'b1;
                busy_seen_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                oHOST_OWN = 1'b0;
                // The controller still reports idle for a cycle after START;
                // completion only counts once it has been seen busy.
                if (!iFHT_RDY) begin
                    busy_seen_d = 1'b1;
                    rd_set_d    = iSOURCE_DATA;
                end else if (busy_seen_q) begin
                    busy_seen_d = 1'b0;
                    state_d     = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                // Occupancy after this cycle's pop plus the read landing now must
                // leave room for one more, so a full-rate stream never stalls.
                issue = !issue_done_q &&
                        (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
                if (issue) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        issue_done_d = 1'b1;
                        rd_cnt_d     = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + IW'(1);
                    end
                end
                if (pop) begin
                    if (out_cnt_q == LAST_IDX) begin
                        out_cnt_d    = '0;
                        issue_done_d = 1'b0;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        state_d      = ST_LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q      <= ST_LOAD;
            load_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            out_cnt_q    <= '0;
            issue_done_q <= 1'b0;
            busy_seen_q  <= 1'b0;
            rd_set_q     <= 1'b0;
            frame_cnt_q  <= '0;
            inflight_q   <= 1'b0;
            rd_bank_q    <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            out_cnt_q    <= out_cnt_d;
            issue_done_q <= issue_done_d;
            busy_seen_q  <= busy_seen_d;
            rd_set_q     <= rd_set_d;
            frame_cnt_q  <= frame_cnt_d;
            inflight_q   <= issue;
            if (issue) begin
                rd_bank_q <= rd_cnt_q[1:0];
            end
        end
    end

    // RAM read data arrives one cycle after issue; pick the bank that was addressed.
    always_comb begin
        case (rd_bank_q)
            2'd0:    q_sel = iRAM_Q0;
            2'd1:    q_sel = iRAM_Q1;
            2'd2:    q_sel = iRAM_Q2;
            default: q_sel = iRAM_Q3;
        endcase
    end

    fht_sched_obuf #(
        .D_BIT (D_BIT)
    ) u_obuf (
        .iCLK        (iCLK),
        .iRESET      (iRESET),
        .iPUSH_VALID (inflight_q),
        .iPUSH_DATA  (q_sel),
        .oOUT_VALID  (obuf_vld),
        .oOUT_DATA   (oOUT_DATA),
        .iOUT_READY  (iOUT_READY),
        .oOCC        (occ)
    );

endmodule

// File: tb/tb_fht_sched.sv
// Bench for fht_sched: random frames checked against a scoreboard of where each
// loaded sample must land and the order it must come back out.
// Honours FHT_SCHED_BITREV_EN the same way the design does.
`timescale 1ns/1ps
module tb_fht_sched;
    import fht_pkg::*;

    localparam int A_BIT = 8;
    localparam int D_BIT = 16;
    localparam int N     = 4 << A_BIT;
    localparam int IW    = A_BIT + 2;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iIN_VALID;
    logic [D_BIT-1:0] iIN_DATA;
    logic             oIN_READY;
    logic             oOUT_VALID;
    logic [D_BIT-1:0] oOUT_DATA;
    logic             oOUT_LAST;
    logic             iOUT_READY;
    logic             oFHT_START;
    logic             iFHT_RDY;
    logic             iSOURCE_DATA;
    logic             oHOST_OWN;
    logic [1:0]       oH_BANK;
    logic [A_BIT-1:0] oH_ADDR;
    logic             oH_WE;
    logic [D_BIT-1:0] oH_WDATA;
    logic             oRD_SET;
    logic [D_BIT-1:0] iRAM_Q0, iRAM_Q1, iRAM_Q2, iRAM_Q3;

    always #5 iCLK = ~iCLK;

    fht_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iIN_VALID(iIN_VALID), .iIN_DATA(iIN_DATA), .oIN_READY(oIN_READY),
        .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA), .oOUT_LAST(oOUT_LAST),
        .iOUT_READY(iOUT_READY),
        .oFHT_START(oFHT_START), .iFHT_RDY(iFHT_RDY), .iSOURCE_DATA(iSOURCE_DATA),
        .oHOST_OWN(oHOST_OWN), .oH_BANK(oH_BANK), .oH_ADDR(oH_ADDR),
        .oH_WE(oH_WE), .oH_WDATA(oH_WDATA), .oRD_SET(oRD_SET),
        .iRAM_Q0(iRAM_Q0), .iRAM_Q1(iRAM_Q1), .iRAM_Q2(iRAM_Q2), .iRAM_Q3(iRAM_Q3)
    );

    // Four banks with registered, one-cycle read; all banks read the host address.
    logic [D_BIT-1:0] ram [4][1 << A_BIT];
    always @(posedge iCLK) begin
        if (oH_WE) ram[oH_BANK][oH_ADDR] <= oH_WDATA;
        iRAM_Q0 <= ram[0][oH_ADDR];
        iRAM_Q1 <= ram[1][oH_ADDR];
        iRAM_Q2 <= ram[2][oH_ADDR];
        iRAM_Q3 <= ram[3][oH_ADDR];
    end

    // Scoreboard: value expected at natural output position k.
    logic [D_BIT-1:0] exp_mem [N];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Where load beat j must be written.
    function automatic int ref_index(input int j);
        int r;
        int x;
        r = j;
`ifdef FHT_SCHED_BITREV_EN
        r = 0;
        x = j;
        for (int i = 0; i < IW; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_in_rdy"}, oIN_READY, 1);
        chk({pfx, "_host_own"}, oHOST_OWN, 1);
        chk({pfx, "_rd_set"}, oRD_SET, 0);
        chk({pfx, "_out_vld"}, oOUT_VALID, 0);
        chk({pfx, "_out_last"}, oOUT_LAST, 0);
        chk({pfx, "_start"}, oFHT_START, 0);
        chk({pfx, "_we"}, oH_WE, 0);
        chk({pfx, "_bank"}, oH_BANK, 0);
        chk({pfx, "_addr"}, oH_ADDR, 0);
    endtask

    task automatic load_frame(input int rst_at);
        int j;
        int guard;
        int idx;
        int rst_pt;
        j = 0;
        guard = 0;
        rst_pt = rst_at;
        while (j < N && guard < 8 * N) begin
            step();
            guard++;
            if (j == rst_pt) begin
                iRESET = 1'b1;
                iIN_VALID = 1'b0;
                step();
                iRESET = 1'b0;
                #1;
                check_reset_values("midrst");
                rst_pt = -1;
                j = 0;
            end else begin
                iIN_VALID = ($urandom_range(99) < 85);
                iIN_DATA = D_BIT'($urandom);
                #1;
                chk("load_in_rdy", oIN_READY, 1);
                chk("load_we", oH_WE, iIN_VALID);
                if (iIN_VALID) begin
                    idx = ref_index(j);
                    chk("load_bank", oH_BANK, idx % 4);
                    chk("load_addr", oH_ADDR, idx / 4);
                    chk("load_wdata", oH_WDATA, iIN_DATA);
                    exp_mem[idx] = iIN_DATA;
                    j++;
                end
            end
        end
        if (j < N) chk("load_timeout", j, N);
        // START cycle: a beat offered here must not be taken.
        step();
        iIN_VALID = 1'b1;
        iIN_DATA = D_BIT'($urandom);
        #1;
        chk("start_pulse", oFHT_START, 1);
        chk("start_host_own", oHOST_OWN, 0);
        chk("start_in_rdy", oIN_READY, 0);
        chk("start_we", oH_WE, 0);
        iIN_VALID = 1'b0;
    endtask

    task automatic run_phase(input int busy, input logic final_src);
        step();
        iFHT_RDY = 1'b1;   // controller not yet busy: must be ignored
        #1;
        chk("run_start_low", oFHT_START, 0);
        chk("run_host_own", oHOST_OWN, 0);
        chk("run_in_rdy", oIN_READY, 0);
        for (int b = 0; b < busy; b++) begin
            step();
            iFHT_RDY = 1'b0;
            iSOURCE_DATA = (b == busy - 1) ? final_src : 1'($urandom_range(1));
            #1;
            chk("busy_host_own", oHOST_OWN, 0);
        end
        step();
        iFHT_RDY = 1'b1;
        iSOURCE_DATA = ~final_src;
        #1;
        chk("done_host_own", oHOST_OWN, 0);
    endtask

    task automatic unload(input int rdy_pct, input logic exp_set);
        int k;
        int cyc;
        int gaps;
        logic first;
        logic pend;
        logic [D_BIT-1:0] pend_dat;
        k = 0;
        cyc = 0;
        gaps = 0;
        first = 1'b1;
        pend = 1'b0;
        pend_dat = '0;
        step();
        iOUT_READY = ($urandom_range(99) < rdy_pct);
        #1;
        chk("unl_rd_set", oRD_SET, exp_set);
        chk("unl_host_own", oHOST_OWN, 1);
        chk("unl_vld_t0", oOUT_VALID, 0);
        chk("unl_in_rdy", oIN_READY, 0);
        chk("unl_we", oH_WE, 0);
        step();
        iOUT_READY = ($urandom_range(99) < rdy_pct);
        #1;
        chk("unl_vld_t1", oOUT_VALID, 0);
        while (k < N && cyc < 40 * N) begin
            step();
            cyc++;
            iOUT_READY = ($urandom_range(99) < rdy_pct);
            #1;
            if (first) chk("unl_vld_t2", oOUT_VALID, 1);
            first = 1'b0;
            if (pend) begin
                chk("vld_hold", oOUT_VALID, 1);
                chk("dat_hold", oOUT_DATA, pend_dat);
            end
            chk("unl_busy_in_rdy", oIN_READY, 0);
            if (oOUT_VALID && iOUT_READY) begin
                chk("out_data", oOUT_DATA, exp_mem[k]);
                chk("out_last", oOUT_LAST, (k == N - 1));
                k++;
            end else if (!oOUT_VALID) begin
                gaps++;
            end
            pend = oOUT_VALID && !iOUT_READY;
            pend_dat = oOUT_DATA;
        end
        if (k < N) chk("unload_timeout", k, N);
        if (rdy_pct >= 100) begin
            chk("unl_gaps", gaps, 0);
            chk("unl_cycles", cyc + 2, N + 2);
        end
        step();
        iOUT_READY = 1'b0;
        #1;
        chk("post_in_rdy", oIN_READY, 1);
        chk("post_host_own", oHOST_OWN, 1);
        chk("post_out_vld", oOUT_VALID, 0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iRESET = 1'b1;
        iIN_VALID = 1'b0;
        iIN_DATA = '0;
        iOUT_READY = 1'b0;
        iFHT_RDY = 1'b1;
        iSOURCE_DATA = 1'b0;
        step();
        step();
        iRESET = 1'b0;
        #1;
        check_reset_values("rst");

        // Frame 1: long busy period ending on set 0, unstalled unload.
        load_frame(-1);
        run_phase(5170, 1'b0);
        unload(100, 1'b0);

        // Frame 2: short busy period ending on set 1, 30% downstream ready.
        load_frame(-1);
        run_phase(int'($urandom_range(60, 10)), 1'b1);
        unload(30, 1'b1);

        // Frame 3: reset at load count 500, then a full frame from index 0.
        load_frame(500);
        run_phase(20, 1'b1);
        unload(100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fht_sched.md
# fht_sched

Frame-level scheduler for the FHT engine. It owns the 4-bank work RAM between frames. It accepts an N = 4·2^A_BIT-point input stream and writes it into the banks, then pulses the FHT controller's start. It then waits for the transform to finish and streams the result out of the correct RAM set with valid/ready back-pressure. It sits between the host streaming interfaces and the existing FHT control/datapath, and drives the RAM-ownership mux.

## Interface
- A_BIT, 8, bank address width; N = 4·2^A_BIT points (1024 default)
- D_BIT, 16, sample width
- iCLK  in  1  clock
- iRESET  in  1  reset; synchronous, active-high
- iIN_VALID  in  1  input sample valid
- iIN_DATA  in  D_BIT  input sample
- oIN_READY  out  1  scheduler accepts input sample
- oOUT_VALID  out  1  result sample valid
- oOUT_DATA  out  D_BIT  result sample
- oOUT_LAST  out  1  marks sample N-1 of a frame
- iOUT_READY  in  1  downstream accepts result
- oFHT_START  out  1  one-cycle start pulse to FHT controller
- iFHT_RDY  in  1  FHT controller ready (high = idle)
- iSOURCE_DATA  in  1  FHT controller RAM-set toggle
- oHOST_OWN  out  1  1 = host side owns RAM ports, 0 = FHT core owns
- oH_BANK  out  2  host-side bank index
- oH_ADDR  out  A_BIT  host-side bank address
- oH_WE  out  1  host-side write enable
- oH_WDATA  out  D_BIT  host-side write data
- oRD_SET  out  1  RAM set holding the result
- iRAM_Q0..iRAM_Q3  in  D_BIT each  bank read data, registered, 1-cycle latency

## Operation
- States: LOAD, START, RUN, UNLOAD. Reset enters LOAD.
- Index mapping for point j: bank = j[1:0], addr = j[A_BIT+1:2].
- LOAD
  - oIN_READY=1, oHOST_OWN=1.
  - On each beat (iIN_VALID & oIN_READY): oH_WE=1, oH_WDATA=iIN_DATA, index = load count (mapped per Configuration); count increments.
  - Beat N-1 moves to START and clears the count.
- START
  - Lasts exactly one cycle. oFHT_START=1, oHOST_OWN=0.
  - Moves to RUN.
- RUN
  - oHOST_OWN=0.
  - A busy_seen flag sets when iFHT_RDY=0 is sampled.
  - While iFHT_RDY=0, iSOURCE_DATA is captured every cycle into oRD_SET.
  - On iFHT_RDY=1 with busy_seen=1, move to UNLOAD; oRD_SET holds its value.
  - iFHT_RDY=1 before busy_seen (the first cycle after START) is ignored.
- UNLOAD
  - oHOST_OWN=1, oH_WE=0.
  - Reads are issued in natural order k=0..N-1 using the same mapping, without bit reversal.
  - The bank index is delayed one cycle to select among iRAM_Q0..3.
  - Data lands in a 2-entry output buffer.
  - A read is issued only when buffered + in-flight < 2, so the buffer never overflows.
  - After beat N-1 is accepted (oOUT_VALID & iOUT_READY & oOUT_LAST): move to LOAD; frame count increments, 16-bit, wrapping.
- oOUT_DATA is undefined while oOUT_VALID=0. oOUT_VALID must not drop until accepted.

## Timing
- Reset values:
  - oIN_READY=1, oHOST_OWN=1, oRD_SET=0.
  - oOUT_VALID=0, oOUT_LAST=0, oFHT_START=0, oH_WE=0, oH_BANK=0, oH_ADDR=0.
  - All counters and the buffer are cleared.
- Reset mid-frame discards all progress. An in-flight FHT run is not aborted; its controller is reset separately.
- Write path is combinational from iIN_VALID/iIN_DATA; the write occurs in the accept cycle.
- The cycle after beat N-1 of LOAD is START; the cycle after that is RUN.
- Unload latency: the read issues in the UNLOAD entry cycle T; oOUT_VALID rises at T+2.
- With iOUT_READY held 1, one sample per cycle; the frame takes N+2 cycles in UNLOAD.
- If iOUT_READY=0, issue stalls within 2 reads. Resuming loses and duplicates nothing.
- oIN_READY=0 in START, RUN and UNLOAD; input beats offered then are not consumed.
- Simultaneous: in the cycle the last beat of UNLOAD is accepted, oIN_READY stays 0; LOAD begins next cycle.

## Configuration
- FHT_SCHED_BITREV_EN defined:
  - The LOAD index is the load count bit-reversed over A_BIT+2 bits (decimation-in-time input order).
  - Output order is unchanged.
- Undefined: the LOAD index is the natural load count.

## Structure
- Shared package fht_pkg:
  - state enum (LOAD, START, RUN, UNLOAD)
  - N_POINT and LOG2_N constants derived from A_BIT
  - 2-bit bank-index typedef
  - bit-reverse function
- Sub-module fht_sched_obuf: the 2-entry valid/ready output buffer with occupancy count. The FSM, counters and mapping stay in fht_sched.

## Test plan
- Load ramp 0..1023 with iIN_VALID=1, macro off.
  - Writes: sample 5 goes to bank 1, addr 1.
  - oFHT_START pulses once, 1 cycle after beat 1023.
- Same load with FHT_SCHED_BITREV_EN.
  - Sample 1 goes to index 512 (bank 0, addr 128).
  - Sample 3 goes to index 768.
- RUN: iFHT_RDY stays 1 one cycle after START, then 0 for 5170 cycles with iSOURCE_DATA toggling, final value 0, then 1.
  - UNLOAD is entered and oRD_SET=0.
  - The early iFHT_RDY=1 is ignored.
- UNLOAD with RAM model q = address, iOUT_READY=1.
  - oOUT_VALID rises 2 cycles after entry.
  - 1024 consecutive beats; oOUT_LAST on beat 1023.
  - oIN_READY=1 the next cycle.
- UNLOAD with iOUT_READY random at 30%: output sequence identical to the unstalled run; no duplicates or gaps.
- Assert iRESET for 1 cycle during load count 500: all outputs return to reset values, and the next frame loads from index 0.
